// File: rtl/turbo_pkg.sv
// turbo_pkg: shared sizes, interleaver table, FSM states and (de)permutation helpers
// for the turbo iteration controller.
package turbo_pkg;
  localparam int NSYM = 7;
  localparam int LLR_W = 4;
  localparam int EXT_W = 12;
  localparam int VW = NSYM * EXT_W;
  localparam int PI [NSYM] = '{3, 6, 2, 5, 1, 4, 0};
  typedef logic [VW-1:0] vec_t;
  typedef enum logic [2:0] {IDLE, ISSUE_NAT, WAIT_NAT, ISSUE_INT, WAIT_INT, OUTPUT} state_t;
  // w selects the element width; narrower vectors ride in the low bits of vec_t
  function automatic vec_t permute(vec_t v, int w);
    vec_t r = '0;
    for (int j = 0; j < NSYM; j++)
      for (int b = 0; b < EXT_W; b++)
        if (b < w) r[j*w+b] = v[PI[j]*w+b];
    return r;
  endfunction
  function automatic vec_t depermute(vec_t v, int w);
    vec_t r = '0;
    for (int j = 0; j < NSYM; j++)
      for (int b = 0; b < EXT_W; b++)
        if (b < w) r[PI[j]*w+b] = v[j*w+b];
    return r;
  endfunction
endpackage

// File: rtl/turbo_iter_ctrl_if.sv
// turbo_iter_ctrl_if: frame input, SISO handshake and decoded-output bundle;
// master is the controller side, slave is the frame source / SISO / sink side.
interface turbo_iter_ctrl_if;
  import turbo_pkg::*;
  logic frame_valid_i;
  logic frame_ready_o;
  logic [NSYM*LLR_W-1:0] frame_sys_i;
  logic [NSYM*LLR_W-1:0] frame_enc1_i;
  logic [NSYM*LLR_W-1:0] frame_enc2_i;
  logic siso_en_o;
  logic [NSYM*LLR_W-1:0] siso_sys_o;
  logic [NSYM*LLR_W-1:0] siso_enc_o;
  logic [NSYM*EXT_W-1:0] siso_ext_o;
  logic [NSYM*EXT_W-1:0] siso_data_i;
  logic siso_finish_i;
  logic dec_valid_o;
  logic dec_ready_i;
  logic [NSYM-1:0] dec_bits_o;
  logic [3:0] iter_used_o;
  modport master (
    input frame_valid_i, frame_sys_i, frame_enc1_i, frame_enc2_i, siso_data_i, siso_finish_i, dec_ready_i,
    output frame_ready_o, siso_en_o, siso_sys_o, siso_enc_o, siso_ext_o, dec_valid_o, dec_bits_o, iter_used_o
  );
  modport slave (
    output frame_valid_i, frame_sys_i, frame_enc1_i, frame_enc2_i, siso_data_i, siso_finish_i, dec_ready_i,
    input frame_ready_o, siso_en_o, siso_sys_o, siso_enc_o, siso_ext_o, dec_valid_o, dec_bits_o, iter_used_o
  );
endinterface

// File: rtl/turbo_hard_dec.sv
// turbo_hard_dec: per-symbol hard decision, bit = sign(sys + ext) at EXT_W+1 bits.
module turbo_hard_dec
  import turbo_pkg::*;
(
  input  logic [NSYM*LLR_W-1:0] sys,
  input  vec_t                  ext,
  output logic [NSYM-1:0]       bits
);
  for (genvar i = 0; i < NSYM; i++) begin : g_sym
    logic signed [EXT_W:0] sum;
    assign sum = (EXT_W+1)'($signed(sys[i*LLR_W +: LLR_W])) + (EXT_W+1)'($signed(ext[i*EXT_W +: EXT_W]));
    assign bits[i] = sum[EXT_W];
  end
endmodule

// File: rtl/turbo_iter_ctrl.sv
// turbo_iter_ctrl: runs the shared SISO in natural/interleaved half-iterations per frame.
// Define TURBO_EARLY_STOP_EN to stop once two consecutive iterations agree on the hard decisions.
module turbo_iter_ctrl
  import turbo_pkg::*;
#(
  parameter int MAX_ITER = 4
) (
  input logic               clk_i,
  input logic               reset_n_i,
  turbo_iter_ctrl_if.master bus
);
  localparam int LV = NSYM * LLR_W;
  state_t state, nxt;
  logic [LV-1:0] sys, enc1, enc2, sys_p;
  vec_t ext_buf, data_p, data_d;
  logic [3:0] iter_cnt, cnt_nx, iter_used;
  logic [NSYM-1:0] dec_bits, hd;
  logic int_ph, fin_nat, fin_int, stop;
  assign sys_p = LV'(permute(VW'(sys), LLR_W));
  assign data_p = permute(bus.siso_data_i, EXT_W);
  assign data_d = depermute(bus.siso_data_i, EXT_W);
  assign int_ph = state == ISSUE_INT || state == WAIT_INT;
  assign fin_nat = state == WAIT_NAT && bus.siso_finish_i;
  assign fin_int = state == WAIT_INT && bus.siso_finish_i;
  assign cnt_nx = iter_cnt + 4'd1;
  turbo_hard_dec u_hd (.sys(sys), .ext(data_d), .bits(hd));
`ifdef TURBO_EARLY_STOP_EN
  // dec_bits still holds the previous iteration's decisions at capture time
  assign stop = cnt_nx == 4'(MAX_ITER) || (cnt_nx >= 4'd2 && hd == dec_bits);
`else
  assign stop = cnt_nx == 4'(MAX_ITER);
`endif
  assign bus.frame_ready_o = state == IDLE;
  assign bus.siso_en_o = state == ISSUE_NAT || state == ISSUE_INT;
  assign bus.dec_valid_o = state == OUTPUT;
  assign bus.siso_sys_o = int_ph ? sys_p : sys;
  assign bus.siso_enc_o = int_ph ? enc2 : enc1;
  assign bus.siso_ext_o = ext_buf;
  assign bus.dec_bits_o = dec_bits;
  assign bus.iter_used_o = iter_used;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = bus.frame_valid_i ? ISSUE_NAT : IDLE;
      ISSUE_NAT: nxt = WAIT_NAT;
      WAIT_NAT:  nxt = bus.siso_finish_i ? ISSUE_INT : WAIT_NAT;
      ISSUE_INT: nxt = WAIT_INT;
      WAIT_INT:  nxt = bus.siso_finish_i ? (stop ? OUTPUT : ISSUE_NAT) : WAIT_INT;
      OUTPUT:    nxt = bus.dec_ready_i ? IDLE : OUTPUT;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
      sys <= '0;
      enc1 <= '0;
      enc2 <= '0;
      ext_buf <= '0;
      iter_cnt <= '0;
      iter_used <= '0;
      dec_bits <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && bus.frame_valid_i) begin
        sys <= bus.frame_sys_i;
        enc1 <= bus.frame_enc1_i;
        enc2 <= bus.frame_enc2_i;
        ext_buf <= '0;
        iter_cnt <= '0;
      end
      if (fin_nat) ext_buf <= data_p;
      if (fin_int) begin
        ext_buf <= data_d;
        iter_cnt <= cnt_nx;
        iter_used <= cnt_nx;
        dec_bits <= hd;
      end
    end
  end
endmodule

// File: doc/turbo_iter_ctrl.md
# turbo_iter_ctrl

Iteration controller for the turbo decoder. It accepts one frame of channel LLRs, then runs the `Siso` core alternately in natural and interleaved order for a fixed number of iterations. Between passes it holds, permutes and de-permutes the extrinsic vector, and at the end it emits hard-decision bits. It sits between the frame source and the single shared `Siso` instance, and owns that instance's `read_en_i`/`finish` handshake.

## Interface
- `NSYM`, 7, symbols per frame.
- `LLR_W`, 4, signed channel LLR width per symbol.
- `EXT_W`, 12, signed extrinsic width per symbol.
- `MAX_ITER`, 4, full iterations per frame (1..15).
- `clk_i` in 1: the single clock.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `frame_valid_i` in 1: frame offered.
- `frame_ready_o` out 1: controller can accept a frame.
- `frame_sys_i` in NSYM*LLR_W: systematic LLRs; element i at `[i*LLR_W +: LLR_W]`.
- `frame_enc1_i` in NSYM*LLR_W: parity of encoder 1, natural order.
- `frame_enc2_i` in NSYM*LLR_W: parity of encoder 2, interleaved order.
- `siso_en_o` out 1: one-cycle start pulse to the `Siso` `read_en_i`.
- `siso_sys_o` out NSYM*LLR_W: systematic LLRs to the SISO.
- `siso_enc_o` out NSYM*LLR_W: parity LLRs to the SISO.
- `siso_ext_o` out NSYM*EXT_W: a-priori LLRs to the SISO.
- `siso_data_i` in NSYM*EXT_W: extrinsic result from the SISO.
- `siso_finish_i` in 1: SISO result valid.
- `dec_valid_o` out 1: decoded frame valid.
- `dec_ready_i` in 1: sink accepts the decoded frame.
- `dec_bits_o` out NSYM: hard decisions, natural order; bit i is symbol i.
- `iter_used_o` out 4: number of full iterations run for this frame.

## Operation
- FSM states: IDLE → ISSUE_NAT → WAIT_NAT → ISSUE_INT → WAIT_INT → (ISSUE_NAT | OUTPUT) → IDLE.
- **IDLE**
  - `frame_ready_o` = 1.
  - On `frame_valid_i`: latch sys/enc1/enc2, clear `ext_buf` to 0, clear `iter_cnt`, go to ISSUE_NAT.
- **ISSUE_NAT**
  - `siso_en_o` = 1 for exactly one cycle.
  - `siso_sys_o` = sys, `siso_enc_o` = enc1, `siso_ext_o` = `ext_buf`.
  - Go to WAIT_NAT.
- **WAIT_NAT**
  - SISO data outputs are held stable.
  - On `siso_finish_i`: `ext_buf` ← PERM(`siso_data_i`), go to ISSUE_INT.
- **ISSUE_INT**
  - `siso_en_o` = 1 for one cycle.
  - `siso_sys_o` = PERM(sys), `siso_enc_o` = enc2, `siso_ext_o` = `ext_buf`.
- **WAIT_INT**
  - On `siso_finish_i`: `ext_buf` ← DEPERM(`siso_data_i`), `iter_cnt`++, register the hard decisions.
  - If `iter_cnt` equals MAX_ITER, go to OUTPUT; otherwise go to ISSUE_NAT.
- **OUTPUT**
  - `dec_valid_o` = 1; `dec_bits_o` and `iter_used_o` are held.
  - On `dec_ready_i`: go to IDLE.
- **Permutation**
  - PERM: out[j] = in[PI[j]], with PI = {3,6,2,5,1,4,0}.
  - DEPERM is the inverse: out[PI[j]] = in[j].
- **Hard decision** for symbol i: sum = sext(sys[i], EXT_W+1) + sext(ext[i], EXT_W+1), computed in natural order. Bit = 1 iff sum < 0. No saturation is needed at EXT_W+1 bits.
- `siso_finish_i` is ignored outside WAIT_NAT and WAIT_INT.
- `frame_valid_i` is ignored outside IDLE.
- If `frame_valid_i` and `dec_ready_i` are both high in OUTPUT, only the drain happens; the new frame is accepted in IDLE, one cycle later at the earliest.
- A reset asserted mid-operation aborts the frame. Any SISO result still in flight after release is discarded.

## Timing
- Reset values:
  - state = IDLE, `frame_ready_o` = 1.
  - `siso_en_o`, `dec_valid_o`, `dec_bits_o`, `iter_used_o` = 0.
  - All `siso_*_o` data outputs and `ext_buf` = 0.
- All outputs are registered or decoded from the state register; there are no combinational paths from inputs to outputs.
- The first `siso_en_o` pulse occurs 1 cycle after frame acceptance.
- A `siso_finish_i` seen at edge t produces the next `siso_en_o` in cycle t+1, so each half-iteration costs SISO latency + 2 cycles.
- `dec_valid_o` rises 1 cycle after the final WAIT_INT capture.
- The frame is released in the cycle `dec_valid_o && dec_ready_i`.

## Configuration
- `TURBO_EARLY_STOP_EN` defined:
  - At each WAIT_INT capture with `iter_cnt` ≥ 2, compare the new hard decisions with the previous iteration's.
  - If they are equal, go to OUTPUT immediately.
  - `iter_used_o` reports the actual count.
- Not defined: always MAX_ITER iterations, and no compare register is synthesized.

## Structure
- `turbo_pkg` holds:
  - NSYM, LLR_W, EXT_W;
  - the PI constant array;
  - the FSM state enum;
  - permute/depermute functions parameterized by element width.
- One sub-module, `turbo_hard_dec`: combinational sign-extend, add and sign-bit extraction over NSYM symbols.

## Test plan
1. **Reset:** hold `reset_n_i` low for 3 cycles → `frame_ready_o` = 1 and every other output is 0.
2. **Full run:** SISO model returns 0, sys all 4'hD (−3), MAX_ITER = 4 → exactly 8 `siso_en_o` pulses, `dec_bits_o` = 7'h7F, `iter_used_o` = 4.
3. **Permutation:** sys elements 0..6 = 0,1,2,3,4,5,6 → the ISSUE_INT `siso_sys_o` elements are 3,6,2,5,1,4,0.
   - The model returns element j = j+1 in the natural pass.
   - The next ISSUE_INT `siso_ext_o` = PERM of that vector: 4,7,3,6,2,5,1.
4. **Backpressure:** `dec_ready_i` held low for 10 cycles → `dec_valid_o` and `dec_bits_o` are stable throughout, `frame_ready_o` = 0, and a concurrent `frame_valid_i` is not accepted.
5. **Reset mid-operation:** reset pulsed during WAIT_INT → outputs return to their reset values; a `siso_finish_i` after release causes no state change.
6. **Early stop:** SISO model returns a constant +5 for all elements.
   - With `TURBO_EARLY_STOP_EN`: `iter_used_o` = 2 and 4 pulses.
   - Without it: `iter_used_o` = 4 and 8 pulses.
